// File: rtl/arbiter_puf.sv
// Digital arbiter PUF, additive delay model: 64 chains evaluated in parallel,
// one switch stage per clock from stage 63 down to stage 0.
module arbiter_puf_chain #(
  parameter logic [31:0] SEED   = 32'hA5A5_5A5A,
  parameter int          CHAIN  = 0,
  parameter int          STAGES = 64,
  parameter int          KW     = $clog2(STAGES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          neg,
  input  logic [KW-1:0] k,
  output logic          pos
);
  // Per-device stage weights, fixed at elaboration; top byte of a hashed (seed, chain, stage).
  function automatic logic [STAGES-1:0][7:0] wtab(input logic [31:0] seed, input int chain);
    logic [31:0] h;
    logic [STAGES-1:0][7:0] t;
    for (int s = 0; s < STAGES; s++) begin
      h    = (seed ^ {20'd0, chain[5:0], s[5:0]}) * 32'h9E37_79B1;
      t[s] = h[31:24];
    end
    return t;
  endfunction

  localparam logic [STAGES-1:0][7:0] WT = wtab(SEED, CHAIN);

  logic signed [15:0] acc, w, nxt;

  assign w   = {{8{WT[k][7]}}, WT[k]};
  assign nxt = neg ? acc - w : acc + w;
  // Sign of the sum after this stage's update; a tie reads as 0.
  assign pos = ~nxt[15] & (|nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= nxt;
  end
endmodule

module arbiter_puf #(
  parameter logic [31:0] SEED   = 32'hA5A5_5A5A,
  parameter int          STAGES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        signal,
  input  logic [63:0] challenge,
  output logic [63:0] response,
  output logic        busy,
  output logic        response_valid
);
  localparam int NUM_LANES = 64;
  localparam int KW        = $clog2(STAGES);

  logic                 sig_q;
  logic [KW-1:0]        k;
  logic                 par;   // 0 = +1, 1 = -1
  logic [63:0]          chal;
  logic                 launch, neg;
  logic [NUM_LANES-1:0] pos;

  assign launch = signal & ~sig_q & ~busy;
  assign neg    = par ^ chal[k];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_chain
    arbiter_puf_chain #(.SEED(SEED), .CHAIN(g), .STAGES(STAGES), .KW(KW)) u_chain (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (launch),
      .en    (busy),
      .neg   (neg),
      .k     (k),
      .pos   (pos[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q          <= 1'b0;
      busy           <= 1'b0;
      k              <= '0;
      par            <= 1'b0;
      chal           <= '0;
      response       <= '0;
      response_valid <= 1'b0;
    end else begin
      sig_q <= signal;
      if (launch) begin
        chal           <= challenge;
        busy           <= 1'b1;
        response_valid <= 1'b0;
        k              <= KW'(STAGES - 1);
        par            <= 1'b0;
      end else if (busy) begin
        par <= neg;
        k   <= k - 1'b1;
        if (k == '0) begin
          busy           <= 1'b0;
          response       <= pos;
          response_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_arbiter_puf.sv
// Directed/random bench for arbiter_puf against a sum-of-products delay model.
module tb_arbiter_puf;
  localparam logic [31:0] SEED = 32'hA5A5_5A5A;
  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        signal;
  logic [63:0] challenge;
  logic [63:0] response;
  logic        busy;
  logic        response_valid;

  int errors = 0;
  int checks = 0;
  logic [63:0] last_exp;

  arbiter_puf #(.SEED(SEED), .STAGES(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .signal         (signal),
    .challenge      (challenge),
    .response       (response),
    .busy           (busy),
    .response_valid (response_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int wgt(input int i, input int k);
    logic [31:0] h;
    h = (SEED ^ 32'((i << 6) | k)) * 32'h9E37_79B1;
    return int'($signed(h[31:24]));
  endfunction

  // acc_i = sum_k phi_k * W(i,k), phi_k = prod_{j>=k} (1 - 2 c[j])
  task automatic model(input logic [63:0] c, output logic [63:0] gt0, output logic [63:0] lt0);
    int acc, phi;
    for (int i = 0; i < 64; i++) begin
      acc = 0;
      for (int k = 0; k < 64; k++) begin
        phi = 1;
        for (int j = k; j < 64; j++) phi = c[j] ? -phi : phi;
        acc += phi * wgt(i, k);
      end
      gt0[i] = (acc > 0);
      lt0[i] = (acc < 0);
    end
  endtask

  // Launch one evaluation from an after-edge point with signal currently low.
  task automatic run(input logic [63:0] c, input string tag);
    logic [63:0] gt, lt;
    challenge = c;
    signal    = 1'b1;
    tick();
    chk({tag, " busy@E0"}, 64'(busy), 64'd1);
    chk({tag, " valid@E0"}, 64'(response_valid), 64'd0);
    chk({tag, " held_resp@E0"}, response, last_exp);
    signal    = 1'b0;
    challenge = {$urandom(), $urandom()};
    repeat (63) tick();
    chk({tag, " busy@E63"}, 64'(busy), 64'd1);
    chk({tag, " valid@E63"}, 64'(response_valid), 64'd0);
    tick();
    model(c, gt, lt);
    chk({tag, " valid@E64"}, 64'(response_valid), 64'd1);
    chk({tag, " busy@E64"}, 64'(busy), 64'd0);
    chk({tag, " resp@E64"}, response, gt);
    last_exp = gt;
  endtask

  initial begin
    logic [63:0] c, c2, gt, lt, first;
    logic        stayed;
    rst_n = 1'b0; signal = 1'b0; challenge = '0;
    repeat (2) tick();
    chk("reset resp", response, 64'd0);
    chk("reset valid", 64'(response_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    last_exp = '0;
    tick();

    run(64'h0, "zero");
    // Back-to-back runs launch at E65, the earliest allowed edge.
    for (int n = 0; n < 4; n++) run({$urandom(), $urandom()}, "rand");

    c = {$urandom(), $urandom()};
    run(c, "sym_a");
    model(c, gt, lt);
    run(c ^ MSB, "sym_b");
    chk("sym invert", response, lt);

    // Retrigger while busy is ignored.
    c  = {$urandom(), $urandom()};
    c2 = {$urandom(), $urandom()};
    challenge = c; signal = 1'b1;
    tick();                                   // E0
    signal = 1'b0;
    repeat (9) tick();
    signal = 1'b1; challenge = ~c; tick();    // E10
    signal = 1'b0;
    repeat (19) tick();
    signal = 1'b1; tick();                    // E30
    signal = 1'b0;
    repeat (33) tick();
    chk("retrig busy@E63", 64'(busy), 64'd1);
    tick();                                   // E64
    model(c, gt, lt);
    chk("retrig valid@E64", 64'(response_valid), 64'd1);
    chk("retrig resp@E64", response, gt);
    tick();                                   // E65
    chk("retrig idle@E65", 64'(busy), 64'd0);
    signal = 1'b1; challenge = c2;
    tick();                                   // E66
    chk("retrig busy@E66", 64'(busy), 64'd1);
    signal = 1'b0;
    repeat (63) tick();
    chk("retrig valid@E129", 64'(response_valid), 64'd0);
    tick();                                   // E130
    model(c2, gt, lt);
    chk("retrig valid@E130", 64'(response_valid), 64'd1);
    chk("retrig resp@E130", response, gt);

    // Asynchronous reset mid-evaluation.
    challenge = {$urandom(), $urandom()}; signal = 1'b1;
    tick();
    signal = 1'b0;
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst valid", 64'(response_valid), 64'd0);
    chk("midrst resp", response, 64'd0);
    tick();
    rst_n = 1'b1;
    last_exp = '0;
    run({$urandom(), $urandom()}, "relaunch");

    // Signal held high from reset release: one evaluation, repeatable.
    first = '0;
    for (int pass = 0; pass < 2; pass++) begin
      rst_n = 1'b0; signal = 1'b1; challenge = 64'hE5F2_803E_30E0_B4BC;
      tick();
      rst_n = 1'b1;
      tick();                                 // E0
      chk("held busy@E0", 64'(busy), 64'd1);
      repeat (63) tick();
      chk("held valid@E63", 64'(response_valid), 64'd0);
      tick();
      model(64'hE5F2_803E_30E0_B4BC, gt, lt);
      chk("held resp@E64", response, gt);
      chk("held valid@E64", 64'(response_valid), 64'd1);
      stayed = 1'b1;
      for (int n = 0; n < 70; n++) begin
        tick();
        if (!response_valid || busy) stayed = 1'b0;
      end
      chk("held single eval", 64'(stayed), 64'd1);
      if (pass == 0) first = response;
      else chk("held repeat", response, first);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
